spmdv_feeder: RTL and testbench

SPMDV_FEEDER -- requirements
Module: spmdv_feeder

---
 rtl/spmdv_pkg.sv | 31 +++
 rtl/spmdv_phase_ctr.sv | 43 ++++
 rtl/spmdv_feeder.sv | 135 +++++++++++++
 tb/tb_spmdv_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spmdv_pkg.sv
// spmdv_pkg: shared constants for the SpMDV feeder and its bench.
// Holds default byte counts, contiguous base addresses, counter width and
// the FSM state encoding, plus a helper that identifies weight/bias phases.
package spmdv_pkg;

  localparam int CTR_W = 15;

  localparam int DEF_N_WVAL = 12288;
  localparam int DEF_N_WPOS = 12288;
  localparam int DEF_N_BIAS = 256;
  localparam int DEF_N_VEC  = 4096;

  // Base addresses for the default layout (weights, positions, bias, vector).
  localparam int DEF_BASE_WVAL = 0;
  localparam int DEF_BASE_WPOS = DEF_N_WVAL;
  localparam int DEF_BASE_BIAS = DEF_N_WVAL + DEF_N_WPOS;
  localparam int DEF_BASE_VEC  = DEF_N_WVAL + DEF_N_WPOS + DEF_N_BIAS;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WVAL = 3'd1;
  localparam logic [2:0] ST_WPOS = 3'd2;
  localparam logic [2:0] ST_BIAS = 3'd3;
  localparam logic [2:0] ST_VEC  = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  // Weight-side phases are the ones driven by ld_w_request.
  function automatic logic is_weight_phase(input logic [2:0] st);
    return (st == ST_WVAL) || (st == ST_WPOS) || (st == ST_BIAS);
  endfunction

endpackage

// File: rtl/spmdv_phase_ctr.sv
// spmdv_phase_ctr: per-phase byte counter with limit, grant and last flag.
// Ports: clk, rst (sync, active-high), clr (force to 0), req (consumer request),
//   limit (phase byte count), cnt (current index), grant, last (final byte granted).
module spmdv_phase_ctr
  import spmdv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             req,
  input  logic [CTR_W-1:0] limit,
  output logic [CTR_W-1:0] cnt,
  output logic             grant,
  output logic             last
);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  assign cnt   = cnt_q;
  assign grant = req && (cnt_q < limit);
  assign last  = grant && (cnt_q == (limit - 1'b1));

  // The final grant clears the counter so the next phase starts at index 0
  // on the very next cycle; this also keeps the count from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || last) begin
      cnt_d = '0;
    end else if (grant) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spmdv_feeder.sv
// spmdv_feeder: streams weight values, weight positions, bias and vector bytes
// from a byte memory to a consumer, one byte per granted request.
// Ports: clk, rst (sync, active-high), start; ld_w_request / raw_data_request
//   from the consumer; mem_rd/mem_addr/mem_rdata to memory (1-cycle read);
//   raw_input + w_input_valid/raw_data_valid to consumer; start_init; done.
module spmdv_feeder
  import spmdv_pkg::*;
#(
  parameter int N_WVAL = DEF_N_WVAL,
  parameter int N_WPOS = DEF_N_WPOS,
  parameter int N_BIAS = DEF_N_BIAS,
  parameter int N_VEC  = DEF_N_VEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ld_w_request,
  input  logic             raw_data_request,
  output logic             mem_rd,
  output logic [CTR_W-1:0] mem_addr,
  input  logic [7:0]       mem_rdata,
  output logic             start_init,
  output logic [7:0]       raw_input,
  output logic             w_input_valid,
  output logic             raw_data_valid,
  output logic             done
);

  localparam logic [CTR_W-1:0] LIM_WVAL  = CTR_W'(N_WVAL);
  localparam logic [CTR_W-1:0] LIM_WPOS  = CTR_W'(N_WPOS);
  localparam logic [CTR_W-1:0] LIM_BIAS  = CTR_W'(N_BIAS);
  localparam logic [CTR_W-1:0] LIM_VEC   = CTR_W'(N_VEC);
  localparam logic [CTR_W-1:0] BASE_WPOS = CTR_W'(N_WVAL);
  localparam logic [CTR_W-1:0] BASE_BIAS = CTR_W'(N_WVAL + N_WPOS);
  localparam logic [CTR_W-1:0] BASE_VEC  = CTR_W'(N_WVAL + N_WPOS + N_BIAS);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             w_vld_q;
  logic             w_vld_d;
  logic             r_vld_q;
  logic             r_vld_d;

  logic             phase_req;
  logic [CTR_W-1:0] phase_lim;
  logic [CTR_W-1:0] phase_base;
  logic [CTR_W-1:0] cnt;
  logic             grant;
  logic             last;

  // Select which request line, limit and base address the shared counter
  // serves in the current phase. Outside the four data phases nothing is granted.
  always_comb begin
    phase_req  = 1'b0;
    phase_lim  = '0;
    phase_base = '0;
    case (state_q)
      ST_WVAL: begin
        phase_req  = ld_w_request;
        phase_lim  = LIM_WVAL;
      end
      ST_WPOS: begin
        phase_req  = ld_w_request;
        phase_lim  = LIM_WPOS;
        phase_base = BASE_WPOS;
      end
      ST_BIAS: begin
        phase_req  = ld_w_request;
        phase_lim  = LIM_BIAS;
        phase_base = BASE_BIAS;
      end
      ST_VEC: begin
        phase_req  = raw_data_request;
        phase_lim  = LIM_VEC;
        phase_base = BASE_VEC;
      end
      default: begin
        phase_req  = 1'b0;
      end
    endcase
  end

  spmdv_phase_ctr u_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == ST_IDLE),
    .req   (phase_req),
    .limit (phase_lim),
    .cnt   (cnt),
    .grant (grant),
    .last  (last)
  );

  // The state moves on the edge after the last grant, so the state register
  // already shows the next phase in the cycle the last byte's valid appears.
  // That is why the valid type is captured at grant time rather than decoded
  // from the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_WVAL;
      ST_WVAL: if (last)  state_d = ST_WPOS;
      ST_WPOS: if (last)  state_d = ST_BIAS;
      ST_BIAS: if (last)  state_d = ST_VEC;
      ST_VEC:  if (last)  state_d = ST_FIN;
      ST_FIN:             state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
    w_vld_d = grant && is_weight_phase(state_q);
    r_vld_d = grant && (state_q == ST_VEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_vld_q <= 1'b0;
      r_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_vld_q <= w_vld_d;
      r_vld_q <= r_vld_d;
    end
  end

  // Every output is forced low while reset is held, including the
  // combinational memory strobe and address.
  assign mem_rd         = grant && !rst;
  assign mem_addr       = rst ? '0 : (phase_base + cnt);
  assign start_init     = !rst && is_weight_phase(state_q);
  assign w_input_valid  = !rst && w_vld_q;
  assign raw_data_valid = !rst && r_vld_q;
  assign raw_input      = (!rst && (w_vld_q || r_vld_q)) ? mem_rdata : 8'h00;
  assign done           = !rst && (state_q == ST_FIN);

endmodule

// File: tb/tb_spmdv_feeder.sv
module tb_spmdv_feeder;
  import spmdv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ld_w_request;
  logic        raw_data_request;
  logic        mem_rd;
  logic [14:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        start_init;
  logic [7:0]  raw_input;
  logic        w_input_valid;
  logic        raw_data_valid;
  logic        done;

  int checks = 0;
  int errors = 0;

  spmdv_feeder dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .ld_w_request     (ld_w_request),
    .raw_data_request (raw_data_request),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .start_init       (start_init),
    .raw_input        (raw_input),
    .w_input_valid    (w_input_valid),
    .raw_data_valid   (raw_data_valid),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [7:0] fdat(input int a);
    return 8'((a * 37 + (a >> 7)) & 255);
  endfunction

  // Backing memory: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? fdat(int'(mem_addr)) : 8'hA5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle mismatch counter; each loop's total is compared once.
  int bad;
  function automatic int diff(input logic [31:0] obs, input logic [31:0] exp);
    return (obs === exp) ? 0 : 1;
  endfunction

  initial begin
    int nw;
    int nr;
    int nd;
    int nrd;
    logic e_rd;
    logic e_v;

    rst = 1'b1; start = 1'b0; ld_w_request = 1'b1; raw_data_request = 1'b1;
    next_cyc();
    next_cyc();
    #1;
    // Reset held with both requests active: everything low.
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_start_init", start_init, 0);
    chk("rst_raw_input", raw_input, 0);
    chk("rst_w_valid", w_input_valid, 0);
    chk("rst_r_valid", raw_data_valid, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; ld_w_request = 1'b0; raw_data_request = 1'b0;
    next_cyc();

    // IDLE ignores requests.
    ld_w_request = 1'b1; raw_data_request = 1'b1;
    #1;
    chk("idle_mem_rd", mem_rd, 0);
    chk("idle_start_init", start_init, 0);
    next_cyc();
    ld_w_request = 1'b0; raw_data_request = 1'b0;

    // Run A: WVAL continuous with raw_data_request also high, then WPOS up to byte 500.
    start = 1'b1;
    #1;
    chk("start_cycle_init", start_init, 0);
    next_cyc();
    start = 1'b0;
    bad = 0;
    for (int k = 0; k <= 12288 + 500; k++) begin
      ld_w_request = 1'b1;
      raw_data_request = (k < 12288);
      #1;
      bad += diff(mem_rd, 1);
      bad += diff(mem_addr, k);
      bad += diff(raw_data_valid, 0);
      bad += diff(start_init, 1);
      bad += diff(done, 0);
      bad += diff(w_input_valid, (k > 0));
      bad += diff(raw_input, (k > 0) ? fdat(k - 1) : 8'h00);
      if (k == 12288) begin
        chk("wpos_first_addr", mem_addr, 12288);
        chk("wval_last_data", raw_input, fdat(12287));
      end
      next_cyc();
    end
    chk("runA_mismatches", bad, 0);

    // Reset with WPOS byte 500 in flight.
    rst = 1'b1; ld_w_request = 1'b1;
    #1;
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_start_init", start_init, 0);
    chk("mid_rst_raw_input", raw_input, 0);
    chk("mid_rst_w_valid", w_input_valid, 0);
    chk("mid_rst_done", done, 0);
    next_cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_w_valid", w_input_valid, 0);
    chk("post_rst_r_valid", raw_data_valid, 0);
    chk("post_rst_raw_input", raw_input, 0);
    chk("post_rst_mem_rd", mem_rd, 0);
    chk("post_rst_start_init", start_init, 0);
    next_cyc();
    ld_w_request = 1'b0;

    // Run B: full sequence restarting at address 0.
    start = 1'b1;
    #1;
    next_cyc();
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 24576; k++) begin
      ld_w_request = 1'b1;
      #1;
      if (k == 0) chk("restart_addr", mem_addr, 0);
      bad += diff(mem_rd, 1);
      bad += diff(mem_addr, k);
      bad += diff(raw_data_valid, 0);
      bad += diff(start_init, 1);
      bad += diff(w_input_valid, (k > 0));
      bad += diff(raw_input, (k > 0) ? fdat(k - 1) : 8'h00);
      next_cyc();
    end
    chk("runB_weight_mismatches", bad, 0);

    // BIAS with toggled request and a stray start pulse.
    bad = 0;
    nw = 0;
    for (int i = 0; i < 512; i++) begin
      ld_w_request = (i % 2 == 0);
      start = (i == 100);
      #1;
      e_rd = (i % 2 == 0);
      e_v  = (i == 0) || (i % 2 == 1);
      bad += diff(mem_rd, e_rd);
      if (e_rd) bad += diff(mem_addr, 24576 + i / 2);
      bad += diff(start_init, (i < 511));
      bad += diff(w_input_valid, e_v);
      bad += diff(raw_data_valid, 0);
      if (i == 0) bad += diff(raw_input, fdat(24575));
      else if (e_v) bad += diff(raw_input, fdat(24576 + (i - 1) / 2));
      else bad += diff(raw_input, 0);
      if (i > 0 && w_input_valid === 1'b1) nw++;
      if (i == 511) chk("bias_last_data", raw_input, fdat(24831));
      next_cyc();
    end
    start = 1'b0;
    chk("bias_pulse_count", nw, 256);
    chk("bias_mismatches", bad, 0);

    // VEC with 4100 requests; ld_w_request held high and ignored.
    bad = 0; nr = 0; nd = 0; nrd = 0;
    for (int v = 0; v < 4100; v++) begin
      raw_data_request = 1'b1;
      ld_w_request = 1'b1;
      #1;
      e_rd = (v < 4096);
      e_v  = (v >= 1) && (v <= 4096);
      bad += diff(mem_rd, e_rd);
      if (e_rd) bad += diff(mem_addr, 24832 + v);
      bad += diff(raw_data_valid, e_v);
      bad += diff(w_input_valid, 0);
      bad += diff(start_init, 0);
      bad += diff(done, (v == 4096));
      if (e_v) bad += diff(raw_input, fdat(24832 + v - 1));
      if (v == 4095) chk("vec_last_addr", mem_addr, 28927);
      if (v == 4096) chk("vec_last_data", raw_input, fdat(28927));
      if (raw_data_valid === 1'b1) nr++;
      if (done === 1'b1) nd++;
      if (mem_rd === 1'b1) nrd++;
      next_cyc();
    end
    chk("vec_valid_count", nr, 4096);
    chk("vec_memrd_count", nrd, 4096);
    chk("done_pulse_count", nd, 1);
    chk("vec_mismatches", bad, 0);

    // Back in IDLE: requests are ignored.
    raw_data_request = 1'b0;
    ld_w_request = 1'b1;
    #1;
    chk("final_idle_mem_rd", mem_rd, 0);
    chk("final_idle_start_init", start_init, 0);
    next_cyc();
    ld_w_request = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
